// File: rtl/id_ex_stage_pkg.sv
// Shared encodings, field layout and the pipeline-register bubble for the ID/EX stage.
// Instruction vectors use ascending [0:N] numbering, so bit 0 is the MSB.
package id_ex_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned WW_W    = 2;
    localparam int unsigned RINS_W  = 6;
    localparam int unsigned DATA_W  = 64;

    localparam int unsigned OP_POS   = 0;
    localparam int unsigned RD_POS   = 6;
    localparam int unsigned RA_POS   = 11;
    localparam int unsigned RB_POS   = 16;
    localparam int unsigned WW_POS   = 24;
    localparam int unsigned RINS_POS = 26;

    typedef logic [0:OP_W-1]   opcode_t;
    typedef logic [0:RINS_W-1] rins_t;
    typedef logic [0:REG_W-1]  reg_t;
    typedef logic [0:WW_W-1]   ww_t;
    typedef logic [0:DATA_W-1] data_t;

    localparam opcode_t OP_R_ALU     = 6'b101010;
    localparam opcode_t OP_LOAD      = 6'b100000;
    localparam opcode_t OP_STORE     = 6'b100001;
    localparam opcode_t OP_BRANCH_EZ = 6'b100010;
    localparam opcode_t OP_BRANCH_NZ = 6'b100011;
    localparam opcode_t OP_NOP       = 6'b111100;

    localparam rins_t R_VNOP = 6'b000000;
    localparam rins_t R_VAND = 6'b000001;
    localparam rins_t R_VOR  = 6'b000010;
    localparam rins_t R_VXOR = 6'b000011;
    localparam rins_t R_VNOT = 6'b000100;
    localparam rins_t R_VMOV = 6'b000101;
    localparam rins_t R_VADD = 6'b000110;
    localparam rins_t R_VSUB = 6'b000111;

    typedef struct packed {
        data_t   a;
        data_t   b;
        opcode_t op;
        rins_t   rins;
        ww_t     ww;
        reg_t    rd;
        logic    wr_en;
        logic    valid;
    } id_ex_t;

    localparam id_ex_t BUBBLE = '{
        a: '0, b: '0, op: OP_NOP, rins: '0, ww: '0, rd: '0, wr_en: 1'b0, valid: 1'b0
    };

    function automatic logic uses_ra(opcode_t op);
        return op inside {OP_R_ALU, OP_LOAD, OP_STORE, OP_BRANCH_EZ, OP_BRANCH_NZ};
    endfunction

    function automatic logic uses_rb(opcode_t op, rins_t rins);
        return ((op == OP_R_ALU) && !(rins inside {R_VNOT, R_VMOV, R_VNOP})) ||
               (op == OP_STORE);
    endfunction

    function automatic logic writes_rd(opcode_t op, rins_t rins);
        return ((op == OP_R_ALU) && (rins != R_VNOP)) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, forwarding sources and registered ALU-side outputs of the ID/EX stage.
// The stage itself connects through the slave modport; the surrounding pipeline uses master.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic [0:INSTR_W-1] if_id_instr;
    logic               if_id_valid;
    data_t              rf_rA_data;
    data_t              rf_rB_data;
    data_t              ex_alu_out;
    logic               exmem_wr_en;
    reg_t               exmem_rd;
    data_t              exmem_data;
    logic               memwb_wr_en;
    reg_t               memwb_rd;
    data_t              memwb_data;
    logic               stall_in;
    logic               flush;

    data_t              rA_64bit_val;
    data_t              rB_64bit_val;
    opcode_t            Op_code;
    rins_t              R_ins;
    ww_t                WW;
    reg_t               ex_rd;
    logic               ex_wr_en;
    logic               ex_valid;
    logic               hazard_stall;

    modport master (
        output if_id_instr, if_id_valid, rf_rA_data, rf_rB_data, ex_alu_out,
               exmem_wr_en, exmem_rd, exmem_data, memwb_wr_en, memwb_rd, memwb_data,
               stall_in, flush,
        input  rA_64bit_val, rB_64bit_val, Op_code, R_ins, WW, ex_rd, ex_wr_en, ex_valid,
               hazard_stall
    );

    modport slave (
        input  if_id_instr, if_id_valid, rf_rA_data, rf_rB_data, ex_alu_out,
               exmem_wr_en, exmem_rd, exmem_data, memwb_wr_en, memwb_rd, memwb_data,
               stall_in, flush,
        output rA_64bit_val, rB_64bit_val, Op_code, R_ins, WW, ex_rd, ex_wr_en, ex_valid,
               hazard_stall
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Priority operand select for one source register: EX, then EX/MEM, then MEM/WB, then the
// register file. An unused operand always takes the register-file value.
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic  used_i,
    input  reg_t  src_i,
    input  data_t rf_data_i,
    input  logic  ex_fwd_en_i,
    input  reg_t  ex_rd_i,
    input  data_t ex_data_i,
    input  logic  exmem_wr_en_i,
    input  reg_t  exmem_rd_i,
    input  data_t exmem_data_i,
    input  logic  memwb_wr_en_i,
    input  reg_t  memwb_rd_i,
    input  data_t memwb_data_i,
    output data_t data_o
);

    always_comb begin
        data_o = rf_data_i;
        if (used_i) begin
            if (ex_fwd_en_i && (ex_rd_i == src_i)) begin
                data_o = ex_data_i;
            end else if (exmem_wr_en_i && (exmem_rd_i == src_i)) begin
                data_o = exmem_data_i;
            end else if (memwb_wr_en_i && (memwb_rd_i == src_i)) begin
                data_o = memwb_data_i;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
// Define FORWARD_EN for forwarding; without it every RAW dependency stalls until write-back.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input logic         clk,
    input logic         reset,
    id_ex_stage_if.slave bus
);

    id_ex_t  q_q, q_d;
    opcode_t dec_op;
    rins_t   dec_rins;
    reg_t    dec_rd, dec_ra, dec_rb;
    ww_t     dec_ww;
    logic    use_a, use_b;
    logic    hazard;
    data_t   opnd_a, opnd_b;

    assign dec_op   = bus.if_id_instr[OP_POS +: OP_W];
    assign dec_rd   = bus.if_id_instr[RD_POS +: REG_W];
    assign dec_ra   = bus.if_id_instr[RA_POS +: REG_W];
    assign dec_rb   = bus.if_id_instr[RB_POS +: REG_W];
    assign dec_ww   = bus.if_id_instr[WW_POS +: WW_W];
    assign dec_rins = bus.if_id_instr[RINS_POS +: RINS_W];

    assign use_a = uses_ra(dec_op);
    assign use_b = uses_rb(dec_op, dec_rins);

`ifdef FORWARD_EN
    logic ex_fwd_en;
    logic unused_instr_bits;

    // A LOAD in EX has no data yet, so it never forwards and instead forces a bubble.
    assign ex_fwd_en = q_q.valid && q_q.wr_en && (q_q.op != OP_LOAD);
    assign hazard    = q_q.valid && (q_q.op == OP_LOAD) &&
                       ((use_a && (q_q.rd == dec_ra)) || (use_b && (q_q.rd == dec_rb)));
    assign unused_instr_bits = ^bus.if_id_instr[21:23];

    id_ex_stage_fwd_mux u_fwd_a (
        .used_i        (use_a),
        .src_i         (dec_ra),
        .rf_data_i     (bus.rf_rA_data),
        .ex_fwd_en_i   (ex_fwd_en),
        .ex_rd_i       (q_q.rd),
        .ex_data_i     (bus.ex_alu_out),
        .exmem_wr_en_i (bus.exmem_wr_en),
        .exmem_rd_i    (bus.exmem_rd),
        .exmem_data_i  (bus.exmem_data),
        .memwb_wr_en_i (bus.memwb_wr_en),
        .memwb_rd_i    (bus.memwb_rd),
        .memwb_data_i  (bus.memwb_data),
        .data_o        (opnd_a)
    );

    id_ex_stage_fwd_mux u_fwd_b (
        .used_i        (use_b),
        .src_i         (dec_rb),
        .rf_data_i     (bus.rf_rB_data),
        .ex_fwd_en_i   (ex_fwd_en),
        .ex_rd_i       (q_q.rd),
        .ex_data_i     (bus.ex_alu_out),
        .exmem_wr_en_i (bus.exmem_wr_en),
        .exmem_rd_i    (bus.exmem_rd),
        .exmem_data_i  (bus.exmem_data),
        .memwb_wr_en_i (bus.memwb_wr_en),
        .memwb_rd_i    (bus.memwb_rd),
        .memwb_data_i  (bus.memwb_data),
        .data_o        (opnd_b)
    );
`else
    logic ex_w;
    logic busy_a, busy_b;
    logic unused_data;

    assign ex_w   = q_q.valid && q_q.wr_en;
    assign busy_a = (ex_w && (q_q.rd == dec_ra)) ||
                    (bus.exmem_wr_en && (bus.exmem_rd == dec_ra)) ||
                    (bus.memwb_wr_en && (bus.memwb_rd == dec_ra));
    assign busy_b = (ex_w && (q_q.rd == dec_rb)) ||
                    (bus.exmem_wr_en && (bus.exmem_rd == dec_rb)) ||
                    (bus.memwb_wr_en && (bus.memwb_rd == dec_rb));
    assign hazard = (use_a && busy_a) || (use_b && busy_b);
    assign opnd_a = bus.rf_rA_data;
    assign opnd_b = bus.rf_rB_data;
    assign unused_data = ^{bus.ex_alu_out, bus.exmem_data, bus.memwb_data,
                           bus.if_id_instr[21:23]};
`endif

    always_comb begin
        q_d = q_q;
        if (!bus.stall_in) begin
            if (bus.flush || hazard || !bus.if_id_valid) begin
                q_d = BUBBLE;
            end else begin
                q_d = '{
                    a:     opnd_a,
                    b:     opnd_b,
                    op:    dec_op,
                    rins:  dec_rins,
                    ww:    dec_ww,
                    rd:    dec_rd,
                    wr_en: writes_rd(dec_op, dec_rins),
                    valid: 1'b1
                };
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= BUBBLE;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.rA_64bit_val = q_q.a;
    assign bus.rB_64bit_val = q_q.b;
    assign bus.Op_code      = q_q.op;
    assign bus.R_ins        = q_q.rins;
    assign bus.WW           = q_q.ww;
    assign bus.ex_rd        = q_q.rd;
    assign bus.ex_wr_en     = q_q.wr_en;
    assign bus.ex_valid     = q_q.valid;
    assign bus.hazard_stall = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for single-cycle behaviour plus sequences
// for forwarding, load-use, flush-under-stall and asynchronous reset.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [0:31] instr;
        logic        valid;
        data_t       rfa;
        data_t       rfb;
        logic        stall;
        logic        flush;
        logic        haz;
        opcode_t     op;
        rins_t       rins;
        ww_t         ww;
        reg_t        rd;
        logic        we;
        logic        vld;
        data_t       a;
        data_t       b;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    function automatic logic [0:31] mk(opcode_t op, reg_t rd, reg_t ra, reg_t rb, ww_t ww,
                                       rins_t rins);
        logic [0:31] i;
        i = '0;
        i[0:5]   = op;
        i[6:10]  = rd;
        i[11:15] = ra;
        i[16:20] = rb;
        i[24:25] = ww;
        i[26:31] = rins;
        return i;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input opcode_t op, input rins_t rins, input ww_t ww,
                           input reg_t rd, input logic we, input logic vld, input data_t a,
                           input data_t b);
        chk({tag, ".op"},   64'(bus.Op_code),  64'(op));
        chk({tag, ".rins"}, 64'(bus.R_ins),    64'(rins));
        chk({tag, ".ww"},   64'(bus.WW),       64'(ww));
        chk({tag, ".rd"},   64'(bus.ex_rd),    64'(rd));
        chk({tag, ".we"},   64'(bus.ex_wr_en), 64'(we));
        chk({tag, ".vld"},  64'(bus.ex_valid), 64'(vld));
        chk({tag, ".a"},    bus.rA_64bit_val,  a);
        chk({tag, ".b"},    bus.rB_64bit_val,  b);
    endtask

    task automatic chk_bubble(input string tag);
        chk_out(tag, OP_NOP, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic chk_haz(input string tag, input logic exp);
        chk({tag, ".haz"}, 64'(bus.hazard_stall), 64'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_id_instr = mk(OP_NOP, 5'd0, 5'd0, 5'd0, 2'd0, 6'd0);
        bus.if_id_valid = 1'b0;
        bus.rf_rA_data  = '0;
        bus.rf_rB_data  = '0;
        bus.ex_alu_out  = '0;
        bus.exmem_wr_en = 1'b0;
        bus.exmem_rd    = '0;
        bus.exmem_data  = '0;
        bus.memwb_wr_en = 1'b0;
        bus.memwb_rd    = '0;
        bus.memwb_data  = '0;
        bus.stall_in    = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic apply(input logic [0:31] instr, input data_t rfa, input data_t rfb);
        bus.if_id_instr = instr;
        bus.if_id_valid = 1'b1;
        bus.rf_rA_data  = rfa;
        bus.rf_rB_data  = rfb;
    endtask

    initial begin
        tbl[0]  = '{mk(OP_R_ALU, 5'd3, 5'd1, 5'd2, 2'd2, R_VADD), 1'b1, 64'h1111, 64'h2222,
                    1'b0, 1'b0, 1'b0, OP_R_ALU, R_VADD, 2'd2, 5'd3, 1'b1, 1'b1, 64'h1111,
                    64'h2222};
        tbl[1]  = '{mk(OP_R_ALU, 5'd10, 5'd11, 5'd12, 2'd0, R_VXOR), 1'b0, 64'h3333,
                    64'h4444, 1'b0, 1'b0, 1'b0, OP_NOP, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0, 64'h0,
                    64'h0};
        tbl[2]  = '{mk(OP_LOAD, 5'd6, 5'd1, 5'd0, 2'd0, 6'd0), 1'b1, 64'h5555, 64'h6666,
                    1'b0, 1'b0, 1'b0, OP_LOAD, 6'd0, 2'd0, 5'd6, 1'b1, 1'b1, 64'h5555,
                    64'h6666};
        tbl[3]  = '{mk(OP_STORE, 5'd5, 5'd2, 5'd4, 2'd1, 6'd0), 1'b1, 64'h7777, 64'h8888,
                    1'b0, 1'b0, 1'b0, OP_STORE, 6'd0, 2'd1, 5'd5, 1'b0, 1'b1, 64'h7777,
                    64'h8888};
        tbl[4]  = '{mk(OP_BRANCH_EZ, 5'd0, 5'd7, 5'd0, 2'd0, 6'd0), 1'b1, 64'h9999, 64'haaaa,
                    1'b0, 1'b0, 1'b0, OP_BRANCH_EZ, 6'd0, 2'd0, 5'd0, 1'b0, 1'b1, 64'h9999,
                    64'haaaa};
        tbl[5]  = '{mk(OP_R_ALU, 5'd1, 5'd2, 5'd3, 2'd3, R_VSUB), 1'b1, 64'hbbbb, 64'hcccc,
                    1'b1, 1'b0, 1'b0, OP_BRANCH_EZ, 6'd0, 2'd0, 5'd0, 1'b0, 1'b1, 64'h9999,
                    64'haaaa};
        tbl[6]  = '{mk(OP_R_ALU, 5'd1, 5'd2, 5'd3, 2'd3, R_VSUB), 1'b1, 64'hbbbb, 64'hcccc,
                    1'b0, 1'b1, 1'b0, OP_NOP, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0, 64'h0, 64'h0};
        tbl[7]  = '{mk(OP_R_ALU, 5'd9, 5'd1, 5'd2, 2'd3, R_VNOP), 1'b1, 64'hdddd, 64'heeee,
                    1'b0, 1'b0, 1'b0, OP_R_ALU, R_VNOP, 2'd3, 5'd9, 1'b0, 1'b1, 64'hdddd,
                    64'heeee};
        tbl[8]  = '{mk(OP_NOP, 5'd4, 5'd4, 5'd4, 2'd0, 6'd0), 1'b1, 64'h1234, 64'h5678,
                    1'b0, 1'b0, 1'b0, OP_NOP, 6'd0, 2'd0, 5'd4, 1'b0, 1'b1, 64'h1234,
                    64'h5678};
        tbl[9]  = '{mk(OP_R_ALU, 5'd12, 5'd13, 5'd13, 2'd1, R_VMOV), 1'b1, 64'habcd,
                    64'hdcba, 1'b0, 1'b0, 1'b0, OP_R_ALU, R_VMOV, 2'd1, 5'd12, 1'b1, 1'b1,
                    64'habcd, 64'hdcba};
        tbl[10] = '{mk(OP_BRANCH_NZ, 5'd0, 5'd14, 5'd14, 2'd0, 6'd0), 1'b1, 64'hf0f0,
                    64'h0f0f, 1'b0, 1'b0, 1'b0, OP_BRANCH_NZ, 6'd0, 2'd0, 5'd0, 1'b0, 1'b1,
                    64'hf0f0, 64'h0f0f};

        idle();
        #12;
        chk_bubble("rst");
        chk_haz("rst", 1'b0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            bus.if_id_instr = tbl[i].instr;
            bus.if_id_valid = tbl[i].valid;
            bus.rf_rA_data  = tbl[i].rfa;
            bus.rf_rB_data  = tbl[i].rfb;
            bus.stall_in    = tbl[i].stall;
            bus.flush       = tbl[i].flush;
            #1;
            chk_haz($sformatf("v%0d", i), tbl[i].haz);
            tick();
            chk_out($sformatf("v%0d", i), tbl[i].op, tbl[i].rins, tbl[i].ww, tbl[i].rd,
                    tbl[i].we, tbl[i].vld, tbl[i].a, tbl[i].b);
        end
        idle();

        // VADD r3 <- r1,r2 then dependent VAND r4 <- r3,r5.
        apply(mk(OP_R_ALU, 5'd3, 5'd1, 5'd2, 2'd0, R_VADD), 64'h1, 64'h2);
        #1;
        chk_haz("raw0", 1'b0);
        tick();
        apply(mk(OP_R_ALU, 5'd4, 5'd3, 5'd5, 2'd0, R_VAND), 64'h0, 64'h5);
        bus.ex_alu_out = 64'h0000_0000_0000_0010;
`ifdef FORWARD_EN
        #1;
        chk_haz("raw1", 1'b0);
        tick();
        chk_out("raw_fwd", OP_R_ALU, R_VAND, 2'd0, 5'd4, 1'b1, 1'b1, 64'h10, 64'h5);
`else
        #1;
        chk_haz("raw_ex", 1'b1);
        tick();
        chk("raw_ex.vld", 64'(bus.ex_valid), 64'd0);
        bus.exmem_wr_en = 1'b1;
        bus.exmem_rd    = 5'd3;
        bus.exmem_data  = 64'h10;
        #1;
        chk_haz("raw_exmem", 1'b1);
        tick();
        chk("raw_exmem.vld", 64'(bus.ex_valid), 64'd0);
        bus.exmem_wr_en = 1'b0;
        bus.memwb_wr_en = 1'b1;
        bus.memwb_rd    = 5'd3;
        bus.memwb_data  = 64'h10;
        #1;
        chk_haz("raw_memwb", 1'b1);
        tick();
        chk("raw_memwb.vld", 64'(bus.ex_valid), 64'd0);
        bus.memwb_wr_en = 1'b0;
        bus.rf_rA_data  = 64'h10;
        #1;
        chk_haz("raw_done", 1'b0);
        tick();
        chk_out("raw_rf", OP_R_ALU, R_VAND, 2'd0, 5'd4, 1'b1, 1'b1, 64'h10, 64'h5);
`endif
        idle();

        // EX/MEM and MEM/WB both write r7: the younger EX/MEM value wins.
        apply(mk(OP_R_ALU, 5'd8, 5'd7, 5'd1, 2'd0, R_VADD), 64'h7777, 64'h1);
        bus.exmem_wr_en = 1'b1;
        bus.exmem_rd    = 5'd7;
        bus.exmem_data  = 64'hAAAA_AAAA_AAAA_AAAA;
        bus.memwb_wr_en = 1'b1;
        bus.memwb_rd    = 5'd7;
        bus.memwb_data  = 64'hBBBB_BBBB_BBBB_BBBB;
`ifdef FORWARD_EN
        #1;
        chk_haz("prio", 1'b0);
        tick();
        chk_out("prio", OP_R_ALU, R_VADD, 2'd0, 5'd8, 1'b1, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA,
                64'h1);
`else
        #1;
        chk_haz("prio", 1'b1);
        tick();
        chk_bubble("prio");
        bus.exmem_wr_en = 1'b0;
        bus.memwb_wr_en = 1'b0;
        #1;
        chk_haz("prio_done", 1'b0);
        tick();
        chk_out("prio_rf", OP_R_ALU, R_VADD, 2'd0, 5'd8, 1'b1, 1'b1, 64'h7777, 64'h1);
`endif
        idle();

        // LOAD r6 then VOR r8 <- r6,r6.
        apply(mk(OP_LOAD, 5'd6, 5'd1, 5'd0, 2'd0, 6'd0), 64'h100, 64'h0);
        #1;
        chk_haz("lu_ld", 1'b0);
        tick();
        apply(mk(OP_R_ALU, 5'd8, 5'd6, 5'd6, 2'd0, R_VOR), 64'h0, 64'h0);
        #1;
        chk_haz("lu_hit", 1'b1);
        tick();
        chk_bubble("lu_bub");
        bus.exmem_wr_en = 1'b1;
        bus.exmem_rd    = 5'd6;
        bus.exmem_data  = 64'hCCCC_CCCC_CCCC_CCCC;
`ifdef FORWARD_EN
        #1;
        chk_haz("lu_fwd", 1'b0);
        tick();
        chk_out("lu_fwd", OP_R_ALU, R_VOR, 2'd0, 5'd8, 1'b1, 1'b1, 64'hCCCC_CCCC_CCCC_CCCC,
                64'hCCCC_CCCC_CCCC_CCCC);
`else
        #1;
        chk_haz("lu_exmem", 1'b1);
        tick();
        chk("lu_exmem.vld", 64'(bus.ex_valid), 64'd0);
        bus.exmem_wr_en = 1'b0;
        bus.memwb_wr_en = 1'b1;
        bus.memwb_rd    = 5'd6;
        #1;
        chk_haz("lu_memwb", 1'b1);
        tick();
        chk("lu_memwb.vld", 64'(bus.ex_valid), 64'd0);
        bus.memwb_wr_en = 1'b0;
        bus.rf_rA_data  = 64'hCCCC_CCCC_CCCC_CCCC;
        bus.rf_rB_data  = 64'hCCCC_CCCC_CCCC_CCCC;
        #1;
        chk_haz("lu_done", 1'b0);
        tick();
        chk_out("lu_rf", OP_R_ALU, R_VOR, 2'd0, 5'd8, 1'b1, 1'b1, 64'hCCCC_CCCC_CCCC_CCCC,
                64'hCCCC_CCCC_CCCC_CCCC);
`endif
        idle();

        // Flush raised during a downstream hold is only honoured once the hold drops.
        apply(mk(OP_R_ALU, 5'd11, 5'd1, 5'd2, 2'd1, R_VXOR), 64'h1, 64'h2);
        tick();
        apply(mk(OP_R_ALU, 5'd13, 5'd14, 5'd15, 2'd0, R_VSUB), 64'h3, 64'h4);
        bus.stall_in = 1'b1;
        bus.flush    = 1'b1;
        #1;
        chk_haz("fl_hold", 1'b0);
        tick();
        chk_out("fl_hold", OP_R_ALU, R_VXOR, 2'd1, 5'd11, 1'b1, 1'b1, 64'h1, 64'h2);
        bus.stall_in = 1'b0;
        tick();
        chk_bubble("fl_bub");
        bus.flush = 1'b0;
        tick();
        chk_out("fl_after", OP_R_ALU, R_VSUB, 2'd0, 5'd13, 1'b1, 1'b1, 64'h3, 64'h4);

        // VNOT r9 <- r2 with EX writing r0 and an unused rB field of 0.
        apply(mk(OP_R_ALU, 5'd0, 5'd1, 5'd1, 2'd0, R_VADD), 64'h9, 64'h9);
        tick();
        apply(mk(OP_R_ALU, 5'd9, 5'd2, 5'd0, 2'd0, R_VNOT), 64'h22, 64'h33);
        bus.ex_alu_out = 64'hDEAD;
        #1;
        chk_haz("vnot", 1'b0);
        tick();
        chk_out("vnot", OP_R_ALU, R_VNOT, 2'd0, 5'd9, 1'b1, 1'b1, 64'h22, 64'h33);

        // Asynchronous reset in the middle of a cycle.
        apply(mk(OP_R_ALU, 5'd8, 5'd1, 5'd2, 2'd0, R_VOR), 64'h55, 64'h66);
        #2;
        reset = 1'b1;
        #1;
        chk_bubble("arst");
        chk_haz("arst", 1'b0);
        #2;
        reset = 1'b0;
        apply(mk(OP_R_ALU, 5'd1, 5'd2, 5'd3, 2'd2, R_VADD), 64'h44, 64'h55);
        tick();
        chk_out("arst_first", OP_R_ALU, R_VADD, 2'd2, 5'd1, 1'b1, 1'b1, 64'h44, 64'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
